// File: rtl/systolic_feed_sched.sv
// rtl/systolic_feed_sched.sv - skewed operand feed sequencer for the systolic array input FIFOs
//
// Purpose: on an init pulse, walks an N x N row-major operand matrix in local
// memory and pushes it into N lane FIFOs with diagonal skew. At step t (0..2N-2),
// lane k carries element (t-k, k) when 0 <= t-k <= N-1 and zero otherwise.
// All lanes of a step are pushed together once no lane FIFO is full. A one-cycle
// com pulse follows the last push.
//
// Ports:
//   clk, rst        system clock; synchronous active-high reset
//   init            start pulse, honoured only while idle
//   base_address    matrix base address, latched when init is accepted
//   busy            high whenever the sequencer is not idle
//   com             one-cycle completion pulse
//   mem_rd/mem_addr operand memory read strobe and address
//   mem_rdata       read data, valid the cycle after mem_rd
//   fifo_full       per-lane FIFO full flags
//   wr_en           per-lane push strobes (all lanes or none)
//   fifo_wdata      lane k data at [k*DATA_W +: DATA_W]
module systolic_feed_sched #(
  parameter int N      = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [ADDR_W-1:0]   base_address,
  output logic                busy,
  output logic                com,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [N-1:0]        fifo_full,
  output logic [N-1:0]        wr_en,
  output logic [N*DATA_W-1:0] fifo_wdata
);

  localparam int TW = $clog2(2*N-1);
  localparam logic [TW-1:0] T_LAST    = TW'(2*N-2);
  localparam logic [TW-1:0] LANE_LAST = TW'(N-1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_PUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [TW-1:0]       t_q, t_d;
  logic [TW-1:0]       k_q, k_d;
  logic [TW-1:0]       kp_q, kp_d;    // lane of the read whose data is in flight
  logic                pend_q, pend_d;
  logic [N*DATA_W-1:0] stage_q, stage_d;

  logic [TW-1:0]       row;
  logic [ADDR_W-1:0]   rd_addr;

  // First and last active lane for step t.
  function automatic logic [TW-1:0] klo_of(input logic [TW-1:0] t);
    return (t > LANE_LAST) ? t - LANE_LAST : '0;
  endfunction

  function automatic logic [TW-1:0] khi_of(input logic [TW-1:0] t);
    return (t > LANE_LAST) ? LANE_LAST : t;
  endfunction

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    t_d        = t_q;
    k_d        = k_q;
    kp_d       = kp_q;
    pend_d     = pend_q;
    stage_d    = stage_q;
    busy       = (state_q != S_IDLE);
    com        = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    wr_en      = '0;
    fifo_wdata = '0;

    // Element (t-k, k) of a row-major matrix; wraps modulo 2^ADDR_W.
    row     = t_q - k_q;
    rd_addr = base_q + ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(k_q);

    // The word requested in the previous cycle lands now.
    if (pend_q) begin
      stage_d[kp_q*DATA_W +: DATA_W] = mem_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (init) begin
          base_d  = base_address;
          t_d     = '0;
          k_d     = '0;
          pend_d  = 1'b0;
          stage_d = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        mem_rd   = 1'b1;
        mem_addr = rd_addr;
        pend_d   = 1'b1;
        kp_d     = k_q;
        if (k_q == khi_of(t_q)) begin
          state_d = S_WAIT;
        end else begin
          k_d = k_q + TW'(1);
        end
      end
      S_WAIT: begin
        pend_d  = 1'b0;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        // Stage holds zeros in inactive lanes, so it is pushed as-is.
        fifo_wdata = stage_q;
        if (fifo_full == '0) begin
          wr_en   = '1;
          stage_d = '0;
          if (t_q == T_LAST) begin
            state_d = S_DONE;
          end else begin
            t_d     = t_q + TW'(1);
            k_d     = klo_of(t_q + TW'(1));
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        com     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      t_q     <= '0;
      k_q     <= '0;
      kp_q    <= '0;
      pend_q  <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      t_q     <= t_d;
      k_q     <= k_d;
      kp_q    <= kp_d;
      pend_q  <= pend_d;
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_systolic_feed_sched.sv
// tb/tb_systolic_feed_sched.sv - self-checking bench for systolic_feed_sched
module tb_systolic_feed_sched;
  localparam int N = 5, DW = 32, AW = 8, MAXC = 160, NSTEP = 2*N-1;

  logic clk = 1'b0;
  logic rst, init, busy, com, mem_rd;
  logic [AW-1:0] base_address, mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [N-1:0] fifo_full, wr_en;
  logic [N*DW-1:0] fifo_wdata;

  systolic_feed_sched #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .init(init), .base_address(base_address),
    .busy(busy), .com(com), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .fifo_full(fifo_full), .wr_en(wr_en),
    .fifo_wdata(fifo_wdata));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  logic [N-1:0]    full_pat [0:MAXC+2];
  logic [N-1:0]    o_wr [0:MAXC+2];
  logic [N*DW-1:0] o_wd [0:MAXC+2];
  logic [AW-1:0]   o_addr [0:MAXC+2];
  logic            o_rd [0:MAXC+2], o_com [0:MAXC+2], o_busy [0:MAXC+2];
  logic [N-1:0]    e_wr [0:MAXC+2];
  logic [N*DW-1:0] e_wd [0:MAXC+2];
  logic [AW-1:0]   e_addr [0:MAXC+2];
  logic            e_rd [0:MAXC+2], e_com [0:MAXC+2], e_busy [0:MAXC+2], e_psc [0:MAXC+2];

  int total = 0, bad = 0;

  function automatic logic [N*DW-1:0] pk(input int a0, a1, a2, a3, a4);
    return {32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  task automatic clear_full();
    for (int i = 0; i <= MAXC+2; i++) full_pat[i] = '0;
  endtask

  // Timeline model: each step reads its active lanes in lane order, one wait
  // cycle, then sits in push until the FIFOs are not full; com follows.
  task automatic build_model(input logic [AW-1:0] b, input int rst_at);
    int c, a;
    logic [N*DW-1:0] d;
    for (int i = 0; i <= MAXC+2; i++) begin
      e_wr[i] = '0; e_wd[i] = '0; e_addr[i] = '0;
      e_rd[i] = 0; e_com[i] = 0; e_busy[i] = 0; e_psc[i] = 0;
    end
    c = 1;
    for (int t = 0; t < NSTEP; t++) begin
      d = '0;
      for (int k = 0; k < N; k++) begin
        if (t - k >= 0 && t - k <= N-1) begin
          a = (int'(b) + (t-k)*N + k) % 256;
          e_rd[c] = 1; e_addr[c] = a[AW-1:0]; d[k*DW +: DW] = mem[a]; c++;
        end
      end
      c++;
      while (full_pat[c] != '0 && c < MAXC) begin
        e_psc[c] = 1; e_wd[c] = d; c++;
      end
      e_psc[c] = 1; e_wr[c] = '1; e_wd[c] = d; c++;
    end
    e_com[c] = 1;
    for (int i = 1; i <= c; i++) e_busy[i] = 1;
    if (rst_at > 0) begin
      for (int i = rst_at+1; i <= MAXC+2; i++) begin
        e_wr[i] = '0; e_rd[i] = 0; e_com[i] = 0; e_busy[i] = 0; e_psc[i] = 0;
      end
    end
  endtask

  // Cycle 1 is the cycle after the edge that samples init.
  task automatic run(input logic [AW-1:0] b, input int ncyc, input int reinit_at, input int rst_at);
    @(posedge clk); #1 base_address = b; init = 1'b1; fifo_full = '0;
    @(posedge clk); #1 init = 1'b0; fifo_full = full_pat[1]; base_address = AW'($urandom);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      o_wr[c] = wr_en; o_wd[c] = fifo_wdata; o_addr[c] = mem_addr;
      o_rd[c] = mem_rd; o_com[c] = com; o_busy[c] = busy;
      @(posedge clk); #1
      fifo_full = full_pat[c+1];
      init = (c+1 == reinit_at);
      rst  = (c+1 == rst_at);
    end
    init = 1'b0; rst = 1'b0; fifo_full = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; fifo_full = '0; base_address = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (com !== 1'b0) begin bad++; $display("FAIL reset_com got=%b exp=0", com); end
    total++; if (wr_en !== '0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    total++; if (fifo_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", fifo_wdata); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [N*DW-1:0] pq[$];
    clear_full(); build_model(8'd0, 0); run(8'd0, 60, 0, 0);
    for (int c = 1; c <= 60; c++) begin
      total++; if (o_wr[c] !== e_wr[c]) begin bad++; $display("FAIL basic_wr c=%0d got=%b exp=%b", c, o_wr[c], e_wr[c]); end
      total++; if (o_com[c] !== e_com[c]) begin bad++; $display("FAIL basic_com c=%0d got=%b exp=%b", c, o_com[c], e_com[c]); end
      total++; if (o_busy[c] !== e_busy[c]) begin bad++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, o_busy[c], e_busy[c]); end
      total++; if (o_rd[c] !== e_rd[c]) begin bad++; $display("FAIL basic_rd c=%0d got=%b exp=%b", c, o_rd[c], e_rd[c]); end
      if (e_rd[c]) begin total++; if (o_addr[c] !== e_addr[c]) begin bad++; $display("FAIL basic_addr c=%0d got=%h exp=%h", c, o_addr[c], e_addr[c]); end end
      if (e_psc[c]) begin total++; if (o_wd[c] !== e_wd[c]) begin bad++; $display("FAIL basic_wdata c=%0d got=%h exp=%h", c, o_wd[c], e_wd[c]); end end
      if (o_wr[c] === '1) pq.push_back(o_wd[c]);
    end
    total++; if (pq.size() != 9) begin bad++; $display("FAIL basic_npush got=%0d exp=9", pq.size()); end
    if (pq.size() == 9) begin
      total++; if (pq[0] !== pk(1,0,0,0,0)) begin bad++; $display("FAIL push0 got=%h exp=%h", pq[0], pk(1,0,0,0,0)); end
      total++; if (pq[1] !== pk(6,2,0,0,0)) begin bad++; $display("FAIL push1 got=%h exp=%h", pq[1], pk(6,2,0,0,0)); end
      total++; if (pq[4] !== pk(21,17,13,9,5)) begin bad++; $display("FAIL push4 got=%h exp=%h", pq[4], pk(21,17,13,9,5)); end
      total++; if (pq[8] !== pk(0,0,0,0,25)) begin bad++; $display("FAIL push8 got=%h exp=%h", pq[8], pk(0,0,0,0,25)); end
    end
    total++; if (o_com[44] !== 1'b1) begin bad++; $display("FAIL basic_com44 got=%b exp=1", o_com[44]); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] aq[$];
    clear_full(); build_model(8'd250, 0); run(8'd250, 60, 0, 0);
    for (int c = 1; c <= 60; c++) begin
      total++; if (o_rd[c] !== e_rd[c]) begin bad++; $display("FAIL wrap_rd c=%0d got=%b exp=%b", c, o_rd[c], e_rd[c]); end
      if (e_rd[c]) begin total++; if (o_addr[c] !== e_addr[c]) begin bad++; $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, o_addr[c], e_addr[c]); end end
      if (e_psc[c]) begin total++; if (o_wd[c] !== e_wd[c]) begin bad++; $display("FAIL wrap_wdata c=%0d got=%h exp=%h", c, o_wd[c], e_wd[c]); end end
      if (o_rd[c] === 1'b1) aq.push_back(o_addr[c]);
    end
    total++; if (aq.size() != 25) begin bad++; $display("FAIL wrap_nreads got=%0d exp=25", aq.size()); end
    if (aq.size() == 25) begin
      total++; if (aq[24] !== 8'd18) begin bad++; $display("FAIL wrap_last_addr got=%0d exp=18", aq[24]); end
    end
  endtask

  task automatic test_stall();
    clear_full();
    for (int c = 3; c <= 5; c++) full_pat[c] = 5'b00100;
    build_model(8'd0, 0); run(8'd0, 60, 0, 0);
    for (int c = 3; c <= 5; c++) begin
      total++; if (o_wr[c] !== '0) begin bad++; $display("FAIL stall_wr c=%0d got=%b exp=0", c, o_wr[c]); end
      total++; if (o_wd[c] !== pk(1,0,0,0,0)) begin bad++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, o_wd[c], pk(1,0,0,0,0)); end
    end
    total++; if (o_wr[6] !== '1 || o_wd[6] !== pk(1,0,0,0,0)) begin bad++; $display("FAIL stall_push got=%b/%h exp=11111/%h", o_wr[6], o_wd[6], pk(1,0,0,0,0)); end
    total++; if (o_com[47] !== 1'b1) begin bad++; $display("FAIL stall_com47 got=%b exp=1", o_com[47]); end
    for (int c = 1; c <= 60; c++) begin
      total++; if (o_wr[c] !== e_wr[c]) begin bad++; $display("FAIL stall_wr_seq c=%0d got=%b exp=%b", c, o_wr[c], e_wr[c]); end
      total++; if (o_com[c] !== e_com[c]) begin bad++; $display("FAIL stall_com_seq c=%0d got=%b exp=%b", c, o_com[c], e_com[c]); end
    end
  endtask

  task automatic test_reinit();
    int np, nc;
    np = 0; nc = 0;
    clear_full(); build_model(8'd0, 0); run(8'd0, 70, 10, 0);
    for (int c = 1; c <= 70; c++) begin
      if (o_wr[c] === '1) np++;
      if (o_com[c] === 1'b1) nc++;
      total++; if (o_wr[c] !== e_wr[c]) begin bad++; $display("FAIL reinit_wr c=%0d got=%b exp=%b", c, o_wr[c], e_wr[c]); end
    end
    total++; if (np != 9) begin bad++; $display("FAIL reinit_npush got=%0d exp=9", np); end
    total++; if (nc != 1) begin bad++; $display("FAIL reinit_ncom got=%0d exp=1", nc); end
  endtask

  task automatic test_midreset();
    int np;
    clear_full(); build_model(8'd0, 20); run(8'd0, 60, 0, 20);
    for (int c = 1; c <= 60; c++) begin
      total++; if (o_wr[c] !== e_wr[c]) begin bad++; $display("FAIL mrst_wr c=%0d got=%b exp=%b", c, o_wr[c], e_wr[c]); end
      total++; if (o_com[c] !== e_com[c]) begin bad++; $display("FAIL mrst_com c=%0d got=%b exp=%b", c, o_com[c], e_com[c]); end
      total++; if (o_busy[c] !== e_busy[c]) begin bad++; $display("FAIL mrst_busy c=%0d got=%b exp=%b", c, o_busy[c], e_busy[c]); end
    end
    np = 0;
    build_model(8'd0, 0); run(8'd0, 60, 0, 0);
    for (int c = 1; c <= 60; c++) begin
      if (o_wr[c] === '1) np++;
      total++; if (o_wr[c] !== e_wr[c]) begin bad++; $display("FAIL mrst2_wr c=%0d got=%b exp=%b", c, o_wr[c], e_wr[c]); end
      if (e_psc[c]) begin total++; if (o_wd[c] !== e_wd[c]) begin bad++; $display("FAIL mrst2_wdata c=%0d got=%h exp=%h", c, o_wd[c], e_wd[c]); end end
    end
    total++; if (np != 9) begin bad++; $display("FAIL mrst2_npush got=%0d exp=9", np); end
    total++; if (o_com[44] !== 1'b1) begin bad++; $display("FAIL mrst2_com44 got=%b exp=1", o_com[44]); end
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      b = AW'($urandom);
      clear_full();
      for (int c = 1; c <= MAXC; c++)
        if ($urandom_range(0, 4) == 0) full_pat[c] = N'($urandom_range(1, 31));
      build_model(b, 0); run(b, 150, 0, 0);
      for (int c = 1; c <= 150; c++) begin
        total++; if (o_wr[c] !== e_wr[c]) begin bad++; $display("FAIL rnd_wr it=%0d c=%0d got=%b exp=%b", it, c, o_wr[c], e_wr[c]); end
        total++; if (o_com[c] !== e_com[c]) begin bad++; $display("FAIL rnd_com it=%0d c=%0d got=%b exp=%b", it, c, o_com[c], e_com[c]); end
        total++; if (o_busy[c] !== e_busy[c]) begin bad++; $display("FAIL rnd_busy it=%0d c=%0d got=%b exp=%b", it, c, o_busy[c], e_busy[c]); end
        total++; if (o_rd[c] !== e_rd[c]) begin bad++; $display("FAIL rnd_rd it=%0d c=%0d got=%b exp=%b", it, c, o_rd[c], e_rd[c]); end
        if (e_rd[c]) begin total++; if (o_addr[c] !== e_addr[c]) begin bad++; $display("FAIL rnd_addr it=%0d c=%0d got=%h exp=%h", it, c, o_addr[c], e_addr[c]); end end
        if (e_psc[c]) begin total++; if (o_wd[c] !== e_wd[c]) begin bad++; $display("FAIL rnd_wdata it=%0d c=%0d got=%h exp=%h", it, c, o_wd[c], e_wd[c]); end end
      end
    end
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; fifo_full = '0; base_address = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'(i + 1);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_reinit();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
